// File: rtl/vertex_unproject_pkg.sv
// Shared half-float types, FSM state encoding and the rounding helper used by the float IPs.
package vertex_unproject_pkg;

  typedef logic [15:0]       f16;
  typedef logic [1:0][15:0]  vec2_f16;  // [0]=x, [1]=y
  typedef logic [2:0][15:0]  vec3_f16;  // [0]=x, [1]=y, [2]=z

  typedef enum logic [2:0] {
    StFlush,
    StIdle,
    StDiv,
    StMul,
    StOut
  } unproject_state_t;

  localparam f16 F16Zero = 16'h0000;
  localparam f16 F16Nan  = 16'h7E00;

  // Round-to-nearest-even and pack; overflow saturates to Inf, underflow flushes to signed zero.
  function automatic f16 f16_round(input logic sign, input int e_in, input logic [9:0] frac,
                                   input logic rnd, input logic sticky);
    logic [10:0] f;
    int          e;
    f = {1'b0, frac} + ((rnd && (sticky || frac[0])) ? 11'd1 : 11'd0);
    e = e_in + (f[10] ? 1 : 0);
    if (e >= 31) return {sign, 5'h1F, 10'h000};
    if (e <= 0)  return {sign, 15'h0000};
    return {sign, e[4:0], f[9:0]};
  endfunction

endpackage

// File: rtl/vertex_unproject_if.sv
// Point-in / vertex-out handshake bundle for vertex_unproject.
interface vertex_unproject_if;
  import vertex_unproject_pkg::*;

  logic    in_valid;
  logic    in_ready;
  vec2_f16 screen_pt;
  f16      depth;
  logic    out_valid;
  logic    out_ready;
  vec3_f16 vertex_3d;
  logic    depth_err;

  modport master (
    output in_valid, screen_pt, depth, out_ready,
    input  in_ready, out_valid, vertex_3d, depth_err
  );

  modport slave (
    input  in_valid, screen_pt, depth, out_ready,
    output in_ready, out_valid, vertex_3d, depth_err
  );
endinterface

// File: rtl/float_divide.sv
// Pipelined f16 divide (a/b), fixed latency; subnormals flush to zero.
module float_divide
  import vertex_unproject_pkg::*;
#(
  parameter int unsigned Latency = 15
) (
  input  logic clk_i,
  input  logic a_tvalid_i,
  input  f16   a_tdata_i,
  input  logic b_tvalid_i,
  input  f16   b_tdata_i,
  output logic res_tvalid_o,
  output f16   res_tdata_o
);

  logic [Latency-1:0] vld_q;
  f16                 dat_q [Latency];
  f16                 res;

  // Combinational quotient with specials, then delayed by the pipeline below.
  always_comb begin
    logic        sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, rem_nz;
    logic [23:0] num, den;
    logic [13:0] q;
    logic [12:0] norm;
    int          e;
    sign   = a_tdata_i[15] ^ b_tdata_i[15];
    a_nan  = (a_tdata_i[14:10] == 5'h1F) && (a_tdata_i[9:0] != 10'd0);
    b_nan  = (b_tdata_i[14:10] == 5'h1F) && (b_tdata_i[9:0] != 10'd0);
    a_inf  = (a_tdata_i[14:10] == 5'h1F) && (a_tdata_i[9:0] == 10'd0);
    b_inf  = (b_tdata_i[14:10] == 5'h1F) && (b_tdata_i[9:0] == 10'd0);
    a_zero = (a_tdata_i[14:10] == 5'h00);
    b_zero = (b_tdata_i[14:10] == 5'h00);
    num    = {1'b1, a_tdata_i[9:0], 13'd0};
    den    = {13'd0, 1'b1, b_tdata_i[9:0]};
    q      = 14'(num / den);
    rem_nz = (num % den) != 24'd0;
    norm   = q[13] ? q[12:0] : {q[11:0], 1'b0};
    e      = int'(a_tdata_i[14:10]) - int'(b_tdata_i[14:10]) + 15 - (q[13] ? 0 : 1);
    res    = f16_round(sign, e, norm[12:3], norm[2], (|norm[1:0]) || rem_nz);
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) res = F16Nan;
    else if (a_inf || b_zero)                                     res = {sign, 5'h1F, 10'h000};
    else if (a_zero || b_inf)                                     res = {sign, 15'h0000};
  end

  // Delay line: valid and data advance together every cycle.
  always_ff @(posedge clk_i) begin
    vld_q[0] <= a_tvalid_i & b_tvalid_i;
    dat_q[0] <= res;
    for (int unsigned i = 1; i < Latency; i++) begin
      vld_q[i] <= vld_q[i-1];
      dat_q[i] <= dat_q[i-1];
    end
  end

  assign res_tvalid_o = vld_q[Latency-1];
  assign res_tdata_o  = dat_q[Latency-1];

endmodule

// File: rtl/float_multiply.sv
// Pipelined f16 multiply, fixed latency; subnormals flush to zero.
module float_multiply
  import vertex_unproject_pkg::*;
#(
  parameter int unsigned Latency = 6
) (
  input  logic clk_i,
  input  logic a_tvalid_i,
  input  f16   a_tdata_i,
  input  logic b_tvalid_i,
  input  f16   b_tdata_i,
  output logic res_tvalid_o,
  output f16   res_tdata_o
);

  logic [Latency-1:0] vld_q;
  f16                 dat_q [Latency];
  f16                 res;

  // Combinational product with specials, then delayed by the pipeline below.
  always_comb begin
    logic        sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [21:0] prod;
    logic [20:0] norm;
    int          e;
    sign   = a_tdata_i[15] ^ b_tdata_i[15];
    a_nan  = (a_tdata_i[14:10] == 5'h1F) && (a_tdata_i[9:0] != 10'd0);
    b_nan  = (b_tdata_i[14:10] == 5'h1F) && (b_tdata_i[9:0] != 10'd0);
    a_inf  = (a_tdata_i[14:10] == 5'h1F) && (a_tdata_i[9:0] == 10'd0);
    b_inf  = (b_tdata_i[14:10] == 5'h1F) && (b_tdata_i[9:0] == 10'd0);
    a_zero = (a_tdata_i[14:10] == 5'h00);
    b_zero = (b_tdata_i[14:10] == 5'h00);
    prod   = 22'({1'b1, a_tdata_i[9:0]}) * 22'({1'b1, b_tdata_i[9:0]});
    norm   = prod[21] ? prod[20:0] : {prod[19:0], 1'b0};
    e      = int'(a_tdata_i[14:10]) + int'(b_tdata_i[14:10]) - 15 + (prod[21] ? 1 : 0);
    res    = f16_round(sign, e, norm[20:11], norm[10], |norm[9:0]);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) res = F16Nan;
    else if (a_inf || b_inf)                                      res = {sign, 5'h1F, 10'h000};
    else if (a_zero || b_zero)                                    res = {sign, 15'h0000};
  end

  // Delay line: valid and data advance together every cycle.
  always_ff @(posedge clk_i) begin
    vld_q[0] <= a_tvalid_i & b_tvalid_i;
    dat_q[0] <= res;
    for (int unsigned i = 1; i < Latency; i++) begin
      vld_q[i] <= vld_q[i-1];
      dat_q[i] <= dat_q[i-1];
    end
  end

  assign res_tvalid_o = vld_q[Latency-1];
  assign res_tdata_o  = dat_q[Latency-1];

endmodule

// File: rtl/vertex_unproject.sv
// Reconstructs a view-space vertex from a screen point and depth: x,y = s * (-z / near).
module vertex_unproject
  import vertex_unproject_pkg::*;
#(
  parameter int unsigned DivLatency = 15,
  parameter int unsigned MulLatency = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  f16                cam_near_clip_i,
  vertex_unproject_if.slave bus_io
);

  localparam int unsigned FlushCycles = DivLatency + MulLatency + 1;
  localparam logic [5:0]  FlushInit   = 6'(FlushCycles);

  unproject_state_t state_q, state_d;
  logic [5:0]       flush_cnt_q, flush_cnt_d;
  f16               xs_q, xs_d, ys_q, ys_d, z_q, z_d, near_q, near_d;
  f16               scale_q, scale_d, x_q, x_d, y_q, y_d;
  logic             err_q, err_d, div_sent_q, div_sent_d, mul_res_q, mul_res_d;
  logic [1:0]       mul_iss_q, mul_iss_d;

  logic in_ready, out_valid, input_bad;
  logic div_in_valid, div_out_valid, mul_in_valid, mul_out_valid;
  f16   div_a, div_res, mul_a, mul_res;

  assign in_ready  = (state_q == StIdle) && !rst_i;
  assign out_valid = (state_q == StOut) && !rst_i;
  // Depth must be strictly negative (-0 rejected) and near strictly positive.
  assign input_bad = !bus_io.depth[15] || (bus_io.depth[14:0] == 15'd0) ||
                     cam_near_clip_i[15] || (cam_near_clip_i[14:0] == 15'd0);
  assign div_a     = {~z_q[15], z_q[14:0]};

  assign bus_io.in_ready  = in_ready;
  assign bus_io.out_valid = out_valid;
  assign bus_io.vertex_3d = out_valid ? {z_q, y_q, x_q} : '0;
  assign bus_io.depth_err = out_valid & err_q;

  float_divide #(.Latency(DivLatency)) u_div (
    .clk_i        (clk_i),
    .a_tvalid_i   (div_in_valid),
    .a_tdata_i    (div_a),
    .b_tvalid_i   (div_in_valid),
    .b_tdata_i    (near_q),
    .res_tvalid_o (div_out_valid),
    .res_tdata_o  (div_res)
  );

  float_multiply #(.Latency(MulLatency)) u_mul (
    .clk_i        (clk_i),
    .a_tvalid_i   (mul_in_valid),
    .a_tdata_i    (mul_a),
    .b_tvalid_i   (mul_in_valid),
    .b_tdata_i    (scale_q),
    .res_tvalid_o (mul_out_valid),
    .res_tdata_o  (mul_res)
  );

  // Next-state and IP issue logic; IP results are only consumed in the state awaiting them.
  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    xs_d         = xs_q;
    ys_d         = ys_q;
    z_d          = z_q;
    near_d       = near_q;
    scale_d      = scale_q;
    x_d          = x_q;
    y_d          = y_q;
    err_d        = err_q;
    div_sent_d   = div_sent_q;
    mul_res_d    = mul_res_q;
    mul_iss_d    = mul_iss_q;
    div_in_valid = 1'b0;
    mul_in_valid = 1'b0;
    mul_a        = xs_q;
    case (state_q)
      StFlush: begin
        if (flush_cnt_q == 6'd0) state_d = StIdle;
        else                     flush_cnt_d = flush_cnt_q - 6'd1;
      end
      StIdle: begin
        if (bus_io.in_valid && in_ready) begin
          xs_d       = bus_io.screen_pt[0];
          ys_d       = bus_io.screen_pt[1];
          z_d        = bus_io.depth;
          near_d     = cam_near_clip_i;
          x_d        = F16Zero;
          y_d        = F16Zero;
          div_sent_d = 1'b0;
          mul_iss_d  = 2'd0;
          mul_res_d  = 1'b0;
          err_d      = input_bad;
          state_d    = input_bad ? StOut : StDiv;
        end
      end
      StDiv: begin
        div_in_valid = !div_sent_q;
        div_sent_d   = 1'b1;
        if (div_sent_q && div_out_valid) begin
          scale_d = div_res;
          state_d = StMul;
        end
      end
      StMul: begin
        if (mul_iss_q != 2'd2) begin
          mul_in_valid = 1'b1;
          mul_a        = (mul_iss_q == 2'd0) ? xs_q : ys_q;
          mul_iss_d    = mul_iss_q + 2'd1;
        end
        if (mul_out_valid) begin
          if (!mul_res_q) begin
            x_d       = mul_res;
            mul_res_d = 1'b1;
          end else begin
            y_d     = mul_res;
            state_d = StOut;
          end
        end
      end
      StOut: begin
        if (bus_io.out_ready) state_d = StIdle;
      end
      default: state_d = StFlush;
    endcase
  end

  // State registers; reset abandons any transaction and restarts the drain window.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StFlush;
      flush_cnt_q <= FlushInit;
      xs_q        <= F16Zero;
      ys_q        <= F16Zero;
      z_q         <= F16Zero;
      near_q      <= F16Zero;
      scale_q     <= F16Zero;
      x_q         <= F16Zero;
      y_q         <= F16Zero;
      err_q       <= 1'b0;
      div_sent_q  <= 1'b0;
      mul_res_q   <= 1'b0;
      mul_iss_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      xs_q        <= xs_d;
      ys_q        <= ys_d;
      z_q         <= z_d;
      near_q      <= near_d;
      scale_q     <= scale_d;
      x_q         <= x_d;
      y_q         <= y_d;
      err_q       <= err_d;
      div_sent_q  <= div_sent_d;
      mul_res_q   <= mul_res_d;
      mul_iss_q   <= mul_iss_d;
    end
  end

endmodule

// File: tb/tb_vertex_unproject.sv
// Directed bench for vertex_unproject: latency, values, error path, backpressure and reset.
module tb_vertex_unproject;
  import vertex_unproject_pkg::*;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  f16   near = 16'h3C00;
  int   checks   = 0;
  int   failures = 0;

  vertex_unproject_if bus ();

  vertex_unproject #(.DivLatency(15), .MulLatency(6)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .cam_near_clip_i (near),
    .bus_io          (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one point for exactly one clock; caller ensures in_ready is high.
  task automatic send(input f16 n, input f16 xs, input f16 ys, input f16 z);
    near          = n;
    bus.screen_pt = {ys, xs};
    bus.depth     = z;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid  = 1'b0;
  endtask

  // Counts cycles from t+1 until out_valid (bounded); flags any in_ready seen meanwhile.
  task automatic wait_out(output int lat, output logic rdy_seen);
    lat      = 1;
    rdy_seen = 1'b0;
    while (bus.out_valid !== 1'b1 && lat < 64) begin
      if (bus.in_ready === 1'b1) rdy_seen = 1'b1;
      step();
      lat++;
    end
    if (bus.in_ready === 1'b1) rdy_seen = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.screen_pt = '0;
    bus.depth = 16'h0000;
    rst = 1'b1;
    step();
    step();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold in_ready=%b out_valid=%b want 0 0", bus.in_ready, bus.out_valid);
    end
    rst = 1'b0;
    for (int i = 0; i < 22; i++) begin
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.depth_err !== 1'b0 ||
          bus.vertex_3d !== 48'h0) begin
        failures++;
        $display("FAIL reset_flush cyc=%0d in_ready=%b out_valid=%b err=%b vtx=%h want 0 0 0 0",
                 i, bus.in_ready, bus.out_valid, bus.depth_err, bus.vertex_3d);
      end
      step();
    end
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 4) begin
      step();
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_to_idle in_ready=%b want 1", bus.in_ready);
    end
  endtask

  task automatic test_normal();
    int   lat;
    logic rdy;
    bus.out_ready = 1'b1;
    send(16'h3C00, 16'h3800, 16'hB400, 16'hC400);
    wait_out(lat, rdy);
    checks++;
    if (lat !== 25) begin
      failures++;
      $display("FAIL normal_latency got=%0d want=25", lat);
    end
    checks++;
    if (bus.vertex_3d !== 48'hC400_BC00_4000) begin
      failures++;
      $display("FAIL normal_vertex got=%h want=c400bc004000", bus.vertex_3d);
    end
    checks++;
    if (bus.depth_err !== 1'b0) begin
      failures++;
      $display("FAIL normal_err got=%b want=0", bus.depth_err);
    end
    checks++;
    if (rdy !== 1'b0) begin
      failures++;
      $display("FAIL normal_in_ready_busy got=%b want=0", rdy);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL normal_release out_valid=%b in_ready=%b want 0 1", bus.out_valid,
               bus.in_ready);
    end
  endtask

  task automatic test_scale_half();
    int   lat;
    logic rdy;
    send(16'h3800, 16'h3C00, 16'h3C00, 16'hC000);
    wait_out(lat, rdy);
    checks++;
    if (lat !== 25 || bus.vertex_3d !== 48'hC000_4400_4400 || bus.depth_err !== 1'b0) begin
      failures++;
      $display("FAIL half_near lat=%0d vtx=%h err=%b want 25 c00044004400 0", lat,
               bus.vertex_3d, bus.depth_err);
    end
    step();
  endtask

  task automatic test_depth_err();
    f16   nears [4] = '{16'h3C00, 16'h3C00, 16'h0000, 16'hBC00};
    f16   zs    [4] = '{16'h3C00, 16'h8000, 16'hC400, 16'hC400};
    int   lat;
    logic rdy;
    logic [47:0] exp_v;
    for (int i = 0; i < 4; i++) begin
      send(nears[i], 16'h3800, 16'h3800, zs[i]);
      wait_out(lat, rdy);
      exp_v = {zs[i], 32'h0};
      checks++;
      if (lat !== 1 || bus.depth_err !== 1'b1 || bus.vertex_3d !== exp_v) begin
        failures++;
        $display("FAIL depth_err case=%0d lat=%0d err=%b vtx=%h want 1 1 %h", i, lat,
                 bus.depth_err, bus.vertex_3d, exp_v);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int   lat;
    logic rdy;
    bus.out_ready = 1'b0;
    send(16'h3C00, 16'h3800, 16'hB400, 16'hC400);
    wait_out(lat, rdy);
    checks++;
    if (lat !== 25) begin
      failures++;
      $display("FAIL bp_latency got=%0d want=25", lat);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.vertex_3d !== 48'hC400_BC00_4000) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d out_valid=%b in_ready=%b vtx=%h want 1 0 c400bc004000",
                 i, bus.out_valid, bus.in_ready, bus.vertex_3d);
      end
      step();
    end
    bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
    end
    send(16'h3800, 16'h3C00, 16'h3C00, 16'hC000);
    wait_out(lat, rdy);
    checks++;
    if (lat !== 25 || bus.vertex_3d !== 48'hC000_4400_4400) begin
      failures++;
      $display("FAIL b2b_second lat=%0d vtx=%h want 25 c00044004400", lat, bus.vertex_3d);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int   lat, n;
    logic rdy;
    send(16'h3C00, 16'h3800, 16'hB400, 16'hC400);
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 22; i++) begin
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.vertex_3d !== 48'h0) begin
        failures++;
        $display("FAIL midrst_flush cyc=%0d in_ready=%b out_valid=%b vtx=%h want 0 0 0", i,
                 bus.in_ready, bus.out_valid, bus.vertex_3d);
      end
      step();
    end
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 4) begin
      step();
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_idle in_ready=%b want 1", bus.in_ready);
    end
    send(16'h3800, 16'h3C00, 16'h3C00, 16'hC000);
    wait_out(lat, rdy);
    checks++;
    if (lat !== 25 || bus.vertex_3d !== 48'hC000_4400_4400 || bus.depth_err !== 1'b0) begin
      failures++;
      $display("FAIL midrst_fresh lat=%0d vtx=%h err=%b want 25 c00044004400 0", lat,
               bus.vertex_3d, bus.depth_err);
    end
    step();
  endtask

  task automatic test_reset_in_out();
    int   n;
    logic ov_seen;
    bus.out_ready = 1'b0;
    send(16'h3C00, 16'h3800, 16'h3800, 16'h3C00);
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL outrst_pre out_valid=%b want 1", bus.out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL outrst_drop out_valid=%b want 0", bus.out_valid);
    end
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    ov_seen = 1'b0;
    while (bus.in_ready !== 1'b1 && n < 30) begin
      if (bus.out_valid === 1'b1) ov_seen = 1'b1;
      step();
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1 || ov_seen !== 1'b0) begin
      failures++;
      $display("FAIL outrst_recover in_ready=%b stale_out=%b want 1 0", bus.in_ready, ov_seen);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_scale_half();
    test_depth_err();
    test_back_to_back();
    test_reset_mid();
    test_reset_in_out();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
